// File: rtl/frame_dump_ctrl.sv
// frame_dump_ctrl: frame-based dump-window controller with per-group probe enable mask
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   vs                vertical sync (clk domain); active edge selected by VS_POL
//   led               asynchronous trigger, synchronised internally
//   arm, abort        1-cycle control pulses
//   cfg_mode          0 OFF, 1 WINDOW, 2 LED, 3 REPEAT
//   cfg_start         first frame / repeat gap
//   cfg_len           frames per window, 0 = unbounded
//   cfg_mask          probe groups enabled in the window
//   frame_cnt         running frame counter
//   dump_en, dump_ch  window active, gated probe-group enables
//   dump_start/stop   window entry/exit pulses
//   dump_frames       ticks counted in the current window
//   busy              armed or dumping
module frame_dump_ctrl #(
  parameter int CW = 32,
  parameter int NCH = 4,
  parameter bit VS_POL = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           vs,
  input  logic           led,
  input  logic           arm,
  input  logic           abort,
  input  logic [1:0]     cfg_mode,
  input  logic [CW-1:0]  cfg_start,
  input  logic [CW-1:0]  cfg_len,
  input  logic [NCH-1:0] cfg_mask,
  output logic [CW-1:0]  frame_cnt,
  output logic           dump_en,
  output logic [NCH-1:0] dump_ch,
  output logic           dump_start,
  output logic           dump_stop,
  output logic [CW-1:0]  dump_frames,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, ARMED, DUMP, DONE} state_t;
  state_t state, state_nxt;
  logic vs_q, vs_qq, led_s1, led_s2, led_s3, tick, led_rise;
  logic [1:0] mode_q;
  logic [CW-1:0] start_q, len_q, target, target_nxt, frame_cnt_nxt, dump_frames_nxt;
  logic [NCH-1:0] mask_q, dump_ch_nxt;
  logic rpt0, rpt0_nxt, cfg_ld, enter, stop_nxt, dump_en_nxt, busy_nxt;
  assign tick = VS_POL ? (vs_qq & ~vs_q) : (~vs_qq & vs_q);
  assign led_rise = led_s2 & ~led_s3;
  assign frame_cnt_nxt = frame_cnt + CW'(tick);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      {vs_q, vs_qq, led_s1, led_s2, led_s3, rpt0} <= '0;
      {mode_q, start_q, len_q, mask_q, target} <= '0;
      frame_cnt   <= '0;
      dump_frames <= '0;
      dump_en     <= 1'b0;
      dump_ch     <= '0;
      dump_start  <= 1'b0;
      dump_stop   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      vs_q        <= vs;
      vs_qq       <= vs_q;
      led_s1      <= led;
      led_s2      <= led_s1;
      led_s3      <= led_s2;
      state       <= state_nxt;
      target      <= target_nxt;
      rpt0        <= rpt0_nxt;
      frame_cnt   <= frame_cnt_nxt;
      if (cfg_ld) {mode_q, start_q, len_q, mask_q} <= {cfg_mode, cfg_start, cfg_len, cfg_mask};
      dump_frames <= dump_frames_nxt;
      dump_en     <= dump_en_nxt;
      dump_ch     <= dump_ch_nxt;
      dump_start  <= enter;
      dump_stop   <= stop_nxt;
      busy        <= busy_nxt;
    end
  end
  // rpt0 marks a REPEAT window with zero gap: re-enter on the very next cycle
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    rpt0_nxt   = rpt0;
    cfg_ld     = 1'b0;
    enter      = 1'b0;
    stop_nxt   = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      stop_nxt  = state == DUMP;
      rpt0_nxt  = 1'b0;
    end else if (arm && (state == IDLE || state == DONE)) begin
      cfg_ld     = 1'b1;
      state_nxt  = cfg_mode != 2'd0 ? ARMED : IDLE;
      target_nxt = cfg_start;
      rpt0_nxt   = 1'b0;
    end else if (state == ARMED) begin
      enter = mode_q == 2'd2 ? led_rise : (rpt0 || (tick && frame_cnt_nxt == target));
      if (enter) begin
        state_nxt = DUMP;
        rpt0_nxt  = 1'b0;
      end
    end else if (state == DUMP && tick && len_q != '0 && dump_frames + CW'(1) == len_q) begin
      stop_nxt   = 1'b1;
      state_nxt  = mode_q == 2'd3 ? ARMED : DONE;
      target_nxt = frame_cnt_nxt + start_q;
      rpt0_nxt   = mode_q == 2'd3 && start_q == '0;
    end
  end
  always_comb begin
    dump_frames_nxt = enter ? '0 : (state == DUMP && tick && !abort) ? dump_frames + CW'(1) : dump_frames;
    dump_en_nxt     = state_nxt == DUMP;
    dump_ch_nxt     = mask_q & {NCH{dump_en_nxt}};
    busy_nxt        = state_nxt == ARMED || state_nxt == DUMP;
  end
endmodule
